// File: rtl/ns_gnrl_pkg.sv
// Shared helpers for the ns_gnrl blocks: width functions and one-hot/index conversion.
package ns_gnrl_pkg;

  localparam int unsigned MAX_VEC_W = 32;
  localparam int unsigned MAX_IDX_W = 5;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the values 0..depth.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Binary index of the lowest set bit (0 when no bit is set).
  function automatic logic [MAX_IDX_W-1:0] oh2idx(input logic [MAX_VEC_W-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [MAX_VEC_W-1:0] idx2oh(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_VEC_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ns_gnrl_rsp_demux_if.sv
// Command/response bus between the shared target path and the requesters.
interface ns_gnrl_rsp_demux_if #(
  parameter int unsigned ARBT_NUM = 4,
  parameter int unsigned DATA_W   = 32
);

  logic [ARBT_NUM-1:0] grt_vec;
  logic                cmd_vld_i;
  logic                cmd_rdy_i;
  logic                cmd_rdy_o;
  logic                rsp_vld_i;
  logic                rsp_rdy_o;
  logic [DATA_W-1:0]   rsp_data_i;
  logic [ARBT_NUM-1:0] rsp_vld_vec;
  logic [ARBT_NUM-1:0] rsp_rdy_vec;
  logic [DATA_W-1:0]   rsp_data_o;
  logic                ost_full;
  logic                ost_empty;
  logic                err;

  // Demux side
  modport slave (
    input  grt_vec, cmd_vld_i, cmd_rdy_i, rsp_vld_i, rsp_data_i, rsp_rdy_vec,
    output cmd_rdy_o, rsp_rdy_o, rsp_vld_vec, rsp_data_o, ost_full, ost_empty, err
  );

  // Driver side (arbiter, target and requesters)
  modport master (
    output grt_vec, cmd_vld_i, cmd_rdy_i, rsp_vld_i, rsp_data_i, rsp_rdy_vec,
    input  cmd_rdy_o, rsp_rdy_o, rsp_vld_vec, rsp_data_o, ost_full, ost_empty, err
  );

endinterface

// File: rtl/ns_gnrl_sync_fifo.sv
// Synchronous FIFO with arbitrary depth; pointers wrap by explicit compare.
module ns_gnrl_sync_fifo
  import ns_gnrl_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = occ_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ns_gnrl_rsp_demux.sv
// Response demux: remembers the owner of each granted command and steers the
// in-order responses back to it. Optional protocol checker: NS_RSP_DEMUX_CHK_EN.
module ns_gnrl_rsp_demux
  import ns_gnrl_pkg::*;
#(
  parameter int unsigned ARBT_NUM  = 4,
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  ns_gnrl_rsp_demux_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(ARBT_NUM);

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] head_idx;

  // Lowest set grant bit becomes the recorded owner.
  assign push_idx = IDX_W'(oh2idx(MAX_VEC_W'(bus.grt_vec)));

  // Command side: ready depends only on the command path and FIFO fullness.
  assign bus.cmd_rdy_o = bus.cmd_rdy_i & ~full;
  assign push          = bus.cmd_vld_i & bus.cmd_rdy_o & (|bus.grt_vec);

  // Response side: route valid/ready to the owner at the FIFO head.
  assign bus.rsp_vld_vec = (bus.rsp_vld_i & ~empty)
                         ? ARBT_NUM'(idx2oh(MAX_IDX_W'(head_idx))) : '0;
  assign bus.rsp_rdy_o   = ~empty & bus.rsp_rdy_vec[head_idx];
  assign bus.rsp_data_o  = bus.rsp_data_i;
  assign pop             = bus.rsp_vld_i & bus.rsp_rdy_o;

  assign bus.ost_full  = full;
  assign bus.ost_empty = empty;

  ns_gnrl_sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OST_DEPTH)
  ) u_ost_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_idx),
    .rdata_o (head_idx),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef NS_RSP_DEMUX_CHK_EN
  logic err_q, err_d;
  logic multi_hot;

  assign multi_hot = |(bus.grt_vec & (bus.grt_vec - ARBT_NUM'(1)));

  // Sticky error on multi-hot grant push or response arriving with nothing outstanding.
  always_comb begin
    err_d = err_q;
    if (push && multi_hot)        err_d = 1'b1;
    if (bus.rsp_vld_i && empty)   err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ns_gnrl_rsp_demux.sv
// Bench for ns_gnrl_rsp_demux: directed scenarios plus random traffic against a queue model.
module tb_ns_gnrl_rsp_demux;

  localparam int unsigned ARBT_NUM  = 4;
  localparam int unsigned OST_DEPTH = 4;
  localparam int unsigned DATA_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ns_gnrl_rsp_demux_if #(.ARBT_NUM(ARBT_NUM), .DATA_W(DATA_W)) bus ();

  ns_gnrl_rsp_demux #(
    .ARBT_NUM  (ARBT_NUM),
    .OST_DEPTH (OST_DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   q[$];
  logic exp_err = 1'b0;
  logic [3:0] obs_vld;
  logic       obs_rdy;
  logic       obs_cmd_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic [3:0] g, input logic cv, input logic cr,
                      input logic rv, input logic [3:0] rr);
    logic [31:0] d;
    logic        empty_m, full_m, push_m, pop_m;
    logic [3:0]  vld_m;
    int          lo;
    d = $urandom;
    @(negedge clk);
    rst             = 1'b0;
    bus.grt_vec     = g;
    bus.cmd_vld_i   = cv;
    bus.cmd_rdy_i   = cr;
    bus.rsp_vld_i   = rv;
    bus.rsp_rdy_vec = rr;
    bus.rsp_data_i  = d;
    #1;
    empty_m = (q.size() == 0);
    full_m  = (q.size() == OST_DEPTH);
    vld_m   = 4'b0;
    pop_m   = 1'b0;
    if (!empty_m) begin
      if (rv) vld_m = 4'(1 << q[0]);
      pop_m = rv && rr[q[0]];
    end
    push_m = cv && cr && !full_m && (g != 4'b0);
    chk("cmd_rdy_o",   64'(bus.cmd_rdy_o),   64'(cr && !full_m));
    chk("rsp_vld_vec", 64'(bus.rsp_vld_vec), 64'(vld_m));
    chk("rsp_rdy_o",   64'(bus.rsp_rdy_o),   64'(!empty_m && rr[empty_m ? 0 : q[0]]));
    chk("rsp_data_o",  64'(bus.rsp_data_o),  64'(d));
    chk("ost_full",    64'(bus.ost_full),    64'(full_m));
    chk("ost_empty",   64'(bus.ost_empty),   64'(empty_m));
    chk("err",         64'(bus.err),         64'(exp_err));
    obs_vld     = bus.rsp_vld_vec;
    obs_rdy     = bus.rsp_rdy_o;
    obs_cmd_rdy = bus.cmd_rdy_o;
    @(posedge clk);
`ifdef NS_RSP_DEMUX_CHK_EN
    if ((push_m && $countones(g) > 1) || (rv && empty_m)) exp_err = 1'b1;
`endif
    if (pop_m) void'(q.pop_front());
    if (push_m) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (g[i]) lo = i;
      q.push_back(lo);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.grt_vec     = '0;
    bus.cmd_vld_i   = 1'b0;
    bus.cmd_rdy_i   = 1'b0;
    bus.rsp_vld_i   = 1'b0;
    bus.rsp_rdy_vec = '0;
    bus.rsp_data_i  = '0;
    @(posedge clk);
    q.delete();
    exp_err = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] g);
    step(g, 1'b1, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic pop_rsp();
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
  endtask

  logic [3:0] exp_own [3];
  logic [3:0] rg;

  initial begin
    bus.grt_vec     = '0;
    bus.cmd_vld_i   = 1'b0;
    bus.cmd_rdy_i   = 1'b0;
    bus.rsp_vld_i   = 1'b0;
    bus.rsp_rdy_vec = '0;
    bus.rsp_data_i  = '0;

    // Reset state
    do_reset();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // In-order return to three owners
    exp_own[0] = 4'b0100; exp_own[1] = 4'b0001; exp_own[2] = 4'b1000;
    for (int i = 0; i < 3; i++) push_cmd(exp_own[i]);
    for (int i = 0; i < 3; i++) begin
      pop_rsp();
      chk("order", 64'(obs_vld), 64'(exp_own[i]));
    end
    #1 chk("empty_after_drain", 64'(bus.ost_empty), 64'd1);

    // Full: push blocked even with a same-cycle pop
    push_cmd(4'b0001); push_cmd(4'b0010); push_cmd(4'b0100); push_cmd(4'b1000);
    #1 chk("full_set", 64'(bus.ost_full), 64'd1);
    step(4'b0001, 1'b1, 1'b1, 1'b1, 4'b1111);
    chk("full_cmd_rdy", 64'(obs_cmd_rdy), 64'd0);
    #1 chk("full_drop", 64'(bus.ost_full), 64'd0);
    for (int i = 0; i < 3; i++) pop_rsp();

    // Steady occupancy 2 with push+pop, wrapping pointers
    push_cmd(4'b0001); push_cmd(4'b0100);
    for (int i = 0; i < 6; i++) begin
      step(4'b0010, 1'b1, 1'b1, 1'b1, 4'b1111);
      chk("wrap_order", 64'(obs_vld), 64'((i == 0) ? 4'b0001 : (i == 1) ? 4'b0100 : 4'b0010));
    end
    pop_rsp(); pop_rsp();

    // Owner not ready holds the response
    push_cmd(4'b0100);
    for (int i = 0; i < 2; i++) begin
      step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1011);
      chk("hold_vld", 64'(obs_vld), 64'b0100);
      chk("hold_rdy", 64'(obs_rdy), 64'd0);
    end
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100);
    chk("release_rdy", 64'(obs_rdy), 64'd1);

    // Response while empty, then multi-hot grant
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
    chk("empty_rsp_rdy", 64'(obs_rdy), 64'd0);
    chk("empty_rsp_vld", 64'(obs_vld), 64'd0);
`ifdef NS_RSP_DEMUX_CHK_EN
    #1 chk("err_empty_rsp", 64'(bus.err), 64'd1);
`else
    #1 chk("err_empty_rsp", 64'(bus.err), 64'd0);
`endif
    push_cmd(4'b0110);
    pop_rsp();
    chk("multi_hot_idx", 64'(obs_vld), 64'b0010);

    // Reset mid-operation discards outstanding entries
    push_cmd(4'b0001); push_cmd(4'b0010); push_cmd(4'b1000);
    do_reset();
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
    chk("post_rst_vld", 64'(obs_vld), 64'd0);
    pop_rsp();

    // Random traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0:       rg = 4'b0000;
        1:       rg = 4'($urandom);
        default: rg = 4'(1 << $urandom_range(0, 3));
      endcase
      step(rg, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) < 3), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
